// File: rtl/syncbus_regfile_if.sv
// Bus-side handshake bundle for syncbus_regfile: address, request and direction from the master; ready/err strobes back.
// Latency: none; these are wires only.
// Backpressure: the master holds address/req/we until ready. The tri-state data bus stays outside because it is a shared net at the bus top.
// Ports/signals: address[ADDR_W] (master->slave), req (master->slave), we (master->slave),
//                ready (slave->master, one-cycle strobe), err (slave->master, coincident with ready).
interface syncbus_regfile_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic              req;
    logic              we;
    logic              ready;
    logic              err;

    modport master (output address, req, we, input ready, err);
    modport slave  (input address, req, we, output ready, err);
endinterface

// File: rtl/syncbus_regfile.sv
// Windowed register file slave on the shared synchronous bus: NREGS registers decoded from a BASE-aligned 2**IDX_W window.
// Latency: ready is high in the cycle WAIT_STATES+1 after the edge that samples req && hit; back-to-back requests have one idle cycle between them.
// Backpressure: the master holds req until ready. Dropping req during the wait states aborts the transfer with no write and no ready.
// Ports: clock, reset_n (async active-low); bus (slave modport: address, req, we in / ready, err out);
//        data (inout, driven only during a read ACK cycle, otherwise Z).
// Build option: define SYNCBUS_ERR_EN so that accesses to holes (idx >= NREGS) raise err together with ready.
module syncbus_regfile #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter int                IDX_W       = 2,
    parameter logic [ADDR_W-1:0] BASE        = 8'hF0,
    parameter int                NREGS       = 3,
    parameter int                WAIT_STATES = 2,
    parameter logic [DATA_W-1:0] RST_VAL     = 8'hE3
) (
    input  logic               clock,
    input  logic               reset_n,
    syncbus_regfile_if.slave   bus,
    inout  wire  [DATA_W-1:0]  data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Loading WAIT_STATES-1 makes the WAIT state last exactly WAIT_STATES cycles.
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t              state;
    logic [3:0]          cnt;
    logic                ready_q;
    logic                err_q;
    logic [DATA_W-1:0]   regs [NREGS];

    logic                hit;
    logic [IDX_W-1:0]    idx;
    logic                hole_err;
    logic [DATA_W-1:0]   rd_dat;

    assign hit = (bus.address[ADDR_W-1:IDX_W] == BASE[ADDR_W-1:IDX_W]);
    assign idx = bus.address[IDX_W-1:0];

`ifdef SYNCBUS_ERR_EN
    localparam logic [IDX_W:0] NREGS_L = NREGS[IDX_W:0];
    assign hole_err = ({1'b0, idx} >= NREGS_L);
`else
    assign hole_err = 1'b0;
`endif

    // Holes match no implemented index, so they read as zero and take no write.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_dat = regs[i];
            end
        end
    end

    // Derived straight from state so that an asynchronous reset releases the bus immediately.
    assign data      = (state == ACK && !bus.we) ? rd_dat : {DATA_W{1'bz}};
    assign bus.ready = ready_q;
    assign bus.err   = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req && hit) begin
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state   <= ACK;
                            ready_q <= 1'b1;
                            err_q   <= hole_err;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.req) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state   <= ACK;
                        ready_q <= 1'b1;
                        err_q   <= hole_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The write lands on the edge that leaves ACK, using the address and data the master presents in ACK.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RST_VAL;
            end
        end else if (state == ACK && bus.we) begin
            for (int i = 0; i < NREGS; i++) begin
                if (idx == IDX_W'(i)) begin
                    regs[i] <= data;
                end
            end
        end
    end

endmodule

// File: tb/tb_syncbus_regfile.sv
// Bench for syncbus_regfile: one instance with WAIT_STATES=2 and one with WAIT_STATES=0, each on its own bus.
// Transfers push expected responses into a scoreboard queue; the monitor pops and compares each ready strobe.
// Pullups on the data nets make a released bus read as all-ones.
`timescale 1ns/1ps
module tb_syncbus_regfile;

    localparam int         NREGS   = 3;
    localparam logic [7:0] RST_VAL = 8'hE3;
`ifdef SYNCBUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int         inst;
        int         due;
        bit         rd;
        logic [7:0] rdat;
        bit         err;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    syncbus_regfile_if #(.ADDR_W(8)) b2 ();
    syncbus_regfile_if #(.ADDR_W(8)) b0 ();

    wire  [7:0] d2;
    wire  [7:0] d0;
    logic       drv2 = 1'b0;
    logic       drv0 = 1'b0;
    logic [7:0] wd2  = 8'h00;
    logic [7:0] wd0  = 8'h00;
    assign d2 = drv2 ? wd2 : 8'hzz;
    assign d0 = drv0 ? wd0 : 8'hzz;
    pullup (d2);
    pullup (d0);

    syncbus_regfile #(.ADDR_W(8), .DATA_W(8), .IDX_W(2), .BASE(8'hF0), .NREGS(NREGS),
                      .WAIT_STATES(2), .RST_VAL(RST_VAL))
        dut2 (.clock(clock), .reset_n(reset_n), .bus(b2), .data(d2));

    syncbus_regfile #(.ADDR_W(8), .DATA_W(8), .IDX_W(2), .BASE(8'hF0), .NREGS(NREGS),
                      .WAIT_STATES(0), .RST_VAL(RST_VAL))
        dut0 (.clock(clock), .reset_n(reset_n), .bus(b0), .data(d0));

    exp_t       sbq[$];
    logic [7:0] model [4];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         ack_seen = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int inst, input logic rdy, input logic er, input logic [7:0] dat, input logic drv);
        exp_t e;
        if (rdy) begin
            ack_seen = 1'b1;
            if (sbq.size() == 0) begin
                chk("unexpected_ready", int'(rdy), 0);
            end else begin
                e = sbq.pop_front();
                chk("ready_instance", inst, e.inst);
                chk("ready_latency", cyc, e.due);
                chk("err_strobe", int'(er), int'(e.err));
                if (e.rd) chk("read_data", int'(dat), int'(e.rdat));
            end
        end else if (!drv) begin
            chk("bus_released", int'(dat), 8'hFF);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            mon(0, b2.ready, b2.err, d2, drv2);
            mon(1, b0.ready, b0.err, d0, drv0);
        end
    end

    // Call at posedge+2; returns at posedge+2 of the cycle after ready, so consecutive calls are back-to-back.
    task automatic xfer(input int inst, input logic [7:0] a, input logic w, input logic [7:0] wd);
        exp_t e;
        bit   h;
        bit   got;
        int   idx;
        h   = (a[7:2] == 6'b111100);
        idx = int'(a[1:0]);
        if (inst == 0) begin
            b2.address = a; b2.we = w; b2.req = 1'b1; drv2 = w; wd2 = wd;
        end else begin
            b0.address = a; b0.we = w; b0.req = 1'b1; drv0 = w; wd0 = wd;
        end
        if (h) begin
            e.inst = inst;
            e.due  = cyc + 1 + ((inst == 0) ? 2 : 0);
            e.rd   = !w;
            e.rdat = (idx < NREGS) ? model[idx] : 8'h00;
            e.err  = ERR_EN && (idx >= NREGS);
            sbq.push_back(e);
            ack_seen = 1'b0;
            got      = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(posedge clock); #2;
                got = ack_seen;
            end
            if (!got) begin
                chk("ready_timeout", 0, 1);
                sbq.delete();
            end
            if (w && idx < NREGS) model[idx] = wd;
        end else begin
            repeat (10) begin
                @(posedge clock); #2;
            end
        end
        if (inst == 0) begin
            b2.req = 1'b0; drv2 = 1'b0;
        end else begin
            b0.req = 1'b0; drv0 = 1'b0;
        end
    endtask

    initial begin
        exp_t       e;
        bit         got;
        logic [7:0] a;

        b2.req = 1'b0; b2.we = 1'b0; b2.address = 8'h00;
        b0.req = 1'b0; b0.we = 1'b0; b0.address = 8'h00;
        for (int i = 0; i < 4; i++) model[i] = RST_VAL;

        #12;
        chk("reset_ready_ws2", int'(b2.ready), 0);
        chk("reset_err_ws2",   int'(b2.err),   0);
        chk("reset_bus_ws2",   int'(d2),       8'hFF);
        chk("reset_ready_ws0", int'(b0.ready), 0);
        chk("reset_bus_ws0",   int'(d0),       8'hFF);
        @(posedge clock); #2;
        reset_n = 1'b1;

        // Reset values, then a write followed by read-back.
        xfer(0, 8'hF0, 1'b0, 8'h00);
        xfer(0, 8'hF1, 1'b0, 8'h00);
        xfer(0, 8'hF2, 1'b0, 8'h00);
        xfer(0, 8'hF1, 1'b1, 8'h5A);
        xfer(0, 8'hF1, 1'b0, 8'h00);
        xfer(0, 8'hF0, 1'b0, 8'h00);
        xfer(0, 8'hF2, 1'b0, 8'h00);

        // Miss held for 10 cycles, then the hole: read, write, read.
        xfer(0, 8'h40, 1'b0, 8'h00);
        xfer(0, 8'hF3, 1'b0, 8'h00);
        xfer(0, 8'hF3, 1'b1, 8'h77);
        xfer(0, 8'hF3, 1'b0, 8'h00);

        // Write aborted during WAIT: no ready, register unchanged.
        @(posedge clock); #2;
        b2.address = 8'hF0; b2.we = 1'b1; wd2 = 8'h11; drv2 = 1'b1; b2.req = 1'b1;
        @(posedge clock); #2;
        b2.req = 1'b0; drv2 = 1'b0;
        repeat (4) begin
            @(posedge clock); #2;
        end
        xfer(0, 8'hF0, 1'b0, 8'h00);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            else                           a = 8'hF0 | 8'($urandom_range(0, 3));
            xfer(0, a, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Reset asserted in the middle of a read ACK cycle.
        @(posedge clock); #2;
        b2.address = 8'hF1; b2.we = 1'b0; b2.req = 1'b1;
        e.inst = 0; e.due = cyc + 3; e.rd = 1'b1; e.rdat = model[1]; e.err = 1'b0;
        sbq.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock);
            got = b2.ready;
        end
        chk("ack_before_reset", int'(got), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_reset_ready", int'(b2.ready), 0);
        chk("mid_reset_err",   int'(b2.err),   0);
        chk("mid_reset_bus",   int'(d2),       8'hFF);
        b2.req = 1'b0;
        sbq.delete();
        for (int i = 0; i < 4; i++) model[i] = RST_VAL;
        @(posedge clock); #2;
        reset_n = 1'b1;
        xfer(0, 8'hF0, 1'b0, 8'h00);
        xfer(0, 8'hF1, 1'b0, 8'h00);
        xfer(0, 8'hF2, 1'b0, 8'h00);

        // Zero wait states: back-to-back reads, then random traffic.
        xfer(1, 8'hF0, 1'b0, 8'h00);
        xfer(1, 8'hF2, 1'b0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            a = 8'hF0 | 8'($urandom_range(0, 3));
            xfer(1, a, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        repeat (3) begin
            @(posedge clock); #2;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
